// File: rtl/sistema_cmp_seq.sv
// sistema_cmp_seq: clocked comparator with a hit counter and a run-lock detector.
//
// On each cycle with in_valid, A and B are compared as unsigned numbers under the
// predicate chosen by mode. The predicate result and the eq/lt/gt flags are
// registered, and out_valid pulses for one cycle. Predicate hits are counted
// into a saturating counter. lock asserts once RUN consecutive valid samples
// have hit. Cycles without in_valid are ignored and do not break a run.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   A, B and mode are sampled this cycle
//   A, B       WIDTH-bit unsigned operands
//   mode       00 EQ, 01 NE, 10 LT (A<B), 11 GT (A>B)
//   clear      synchronous clear of hit_count and the run detector
//   Q          registered predicate result
//   eq/lt/gt   registered relation flags; exactly one is set after any sample
//   out_valid  one-cycle pulse when Q/eq/lt/gt were loaded
//   hit_count  saturating count of hits
//   lock       high while the last RUN valid samples were all hits
//
// Run detector states:
//   state  | meaning
//   SEARCH | no current run (run_cnt = 0)
//   RUN_ST | run in progress, 0 < run_cnt < RUN
//   LOCK   | at least RUN consecutive hits; lock = 1

module sistema_cmp_seq #(
    parameter int WIDTH = 4,
    parameter int RUN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             Q,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             out_valid,
    output logic [CNT_W-1:0] hit_count,
    output logic             lock
);

    localparam int              RC_W  = $clog2(RUN + 1);
    localparam logic [RC_W-1:0] RUN_C = RC_W'(RUN);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        RUN_ST = 2'b01,
        LOCK   = 2'b10
    } state_t;

    state_t          state_q, state_n;
    logic [RC_W-1:0] run_cnt_q, run_cnt_n;
    logic            pred;
    logic            a_eq_b, a_lt_b, a_gt_b;

    assign a_eq_b = (A == B);
    assign a_lt_b = (A < B);
    assign a_gt_b = (A > B);

    always_comb begin
        pred = 1'b0;
        case (mode)
            2'b00:   pred = a_eq_b;
            2'b01:   pred = !a_eq_b;
            2'b10:   pred = a_lt_b;
            2'b11:   pred = a_gt_b;
            default: pred = 1'b0;
        endcase
    end

    // Next run state. A miss always drops back to SEARCH; clear overrides a hit.
    always_comb begin
        state_n   = state_q;
        run_cnt_n = run_cnt_q;
        if (clear) begin
            state_n   = SEARCH;
            run_cnt_n = '0;
        end else if (in_valid) begin
            if (!pred) begin
                state_n   = SEARCH;
                run_cnt_n = '0;
            end else begin
                case (state_q)
                    SEARCH: begin
                        run_cnt_n = RC_W'(1);
                        state_n   = (RUN == 1) ? LOCK : RUN_ST;
                    end
                    RUN_ST: begin
                        run_cnt_n = run_cnt_q + RC_W'(1);
                        if (run_cnt_q + RC_W'(1) == RUN_C) begin
                            state_n = LOCK;
                        end
                    end
                    LOCK: begin
                        state_n   = LOCK;
                        run_cnt_n = run_cnt_q;
                    end
                    default: begin
                        state_n   = SEARCH;
                        run_cnt_n = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            run_cnt_q <= run_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Q         <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            out_valid <= 1'b0;
            hit_count <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Q  <= pred;
                eq <= a_eq_b;
                lt <= a_lt_b;
                gt <= a_gt_b;
            end
            if (clear) begin
                hit_count <= '0;
            end else if (in_valid && pred && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

    assign lock = (state_q == LOCK);

endmodule

// File: tb/tb_sistema_cmp_seq.sv
// Scoreboard bench for sistema_cmp_seq (WIDTH=4, RUN=3, CNT_W=4).
// The driver updates a behavioural model and queues the expected response for
// every valid sample. The monitor pops an entry each time out_valid is seen.
// Idle and reset cycles are checked by the driver against the held model state.

module tb_sistema_cmp_seq;

    localparam int WIDTH = 4;
    localparam int RUN   = 3;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [1:0]       mode = 2'b00;
    logic             clear = 1'b0;
    logic             Q, eq, lt, gt, out_valid, lock;
    logic [CNT_W-1:0] hit_count;

    sistema_cmp_seq #(.WIDTH(WIDTH), .RUN(RUN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .mode(mode),
        .clear(clear), .Q(Q), .eq(eq), .lt(lt), .gt(gt), .out_valid(out_valid),
        .hit_count(hit_count), .lock(lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic q, e, l, g;
        int   hits;
        logic lk;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    // behavioural model state
    logic m_q = 0, m_e = 0, m_l = 0, m_g = 0;
    int   m_hits   = 0;
    int   m_streak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic predicate(input int m, input int a, input int b);
        case (m)
            0: return a == b;
            1: return a != b;
            2: return a < b;
            default: return a > b;
        endcase
    endfunction

    task automatic step(input logic r, input logic v, input int a, input int b,
                        input int m, input logic c);
        exp_t e;
        logic p;
        @(negedge clk);
        rst = r; in_valid = v; A = WIDTH'(a); B = WIDTH'(b); mode = 2'(m); clear = c;
        if (r) begin
            m_q = 0; m_e = 0; m_l = 0; m_g = 0;
            m_hits = 0; m_streak = 0;
        end else begin
            p = predicate(m, a, b);
            if (v) begin
                m_q = p; m_e = (a == b); m_l = (a < b); m_g = (a > b);
            end
            if (c) begin
                m_hits = 0; m_streak = 0;
            end else if (v) begin
                if (p) begin
                    m_hits   = (m_hits < MAXC) ? m_hits + 1 : MAXC;
                    m_streak = m_streak + 1;
                end else begin
                    m_streak = 0;
                end
            end
            if (v) begin
                e.q = m_q; e.e = m_e; e.l = m_l; e.g = m_g;
                e.hits = m_hits; e.lk = (m_streak >= RUN);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (r || !v) begin
            chk("idle_out_valid", 32'(out_valid), 0);
            chk("idle_q",         32'(Q), 32'(m_q));
            chk("idle_eq_lt_gt",  32'({eq, lt, gt}), 32'({m_e, m_l, m_g}));
            chk("idle_hit_count", 32'(hit_count), 32'(m_hits));
            chk("idle_lock",      32'(lock), 32'(m_streak >= RUN));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("q",         32'(Q), 32'(e.q));
                chk("eq",        32'(eq), 32'(e.e));
                chk("lt",        32'(lt), 32'(e.l));
                chk("gt",        32'(gt), 32'(e.g));
                chk("onehot",    32'($onehot({eq, lt, gt})), 1);
                chk("hit_count", 32'(hit_count), 32'(e.hits));
                chk("lock",      32'(lock), 32'(e.lk));
            end
        end
    end

    initial begin
        // reset held for two cycles with a valid equal pair present
        step(1, 1, 5, 5, 0, 0);
        step(1, 1, 5, 5, 0, 0);
        // basic compare
        step(0, 1, 5, 5, 0, 0);
        step(0, 1, 5, 4, 0, 0);
        // lock with an idle gap, then a miss
        step(0, 1, 15, 15, 0, 0);
        step(0, 1, 15, 15, 0, 0);
        step(0, 0, 15, 15, 0, 0);
        step(0, 1, 15, 15, 0, 0);
        step(0, 1, 10, 11, 0, 0);
        // saturation
        for (int i = 0; i < 20; i++) step(0, 1, 7, 7, 0, 0);
        // exhaustive, all modes
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    step(0, 1, a, b, m, 0);
        // clear mid-run, then reset mid-lock
        step(0, 1, 1, 2, 0, 0);
        step(0, 1, 3, 3, 0, 0);
        step(0, 1, 3, 3, 0, 0);
        step(0, 1, 3, 3, 0, 1);
        step(0, 1, 3, 3, 0, 0);
        step(0, 1, 3, 3, 0, 0);
        step(0, 1, 3, 3, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // clear on an idle cycle
        step(0, 1, 9, 9, 0, 0);
        step(0, 0, 9, 9, 0, 1);
        // randomized traffic, equal pairs biased in so runs and locks occur
        for (int i = 0; i < 400; i++) begin
            int a, b;
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 1) == 0) ? a : int'($urandom_range(0, 15));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), a, b,
                 int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
